// File: rtl/cellrv32_cpu_cp_fpu_f2i_gen.sv
// Multi-cycle binary32 -> signed/unsigned integer converter (32-bit, or 64-bit when XLEN=64).
// Define CELLRV32_F2I_BARREL_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shift.
module cellrv32_cpu_cp_fpu_f2i_gen #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [2:0]      rmode_i,
  input  logic [1:0]      funct_i,
  input  logic            sign_i,
  input  logic [7:0]      exponent_i,
  input  logic [22:0]     mantissa_i,
  input  logic [9:0]      class_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      flags_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic [2:0] {S_IDLE, S_PREPARE, S_SHIFT, S_ROUND, S_FINALIZE} state_t;
  state_t state_q, state_d;

  logic [2:0]      rmode_q;
  logic            uns_q, w64_q, sign_q;
  logic [7:0]      exp_q;
  logic [22:0]     frac_q;
  logic [9:0]      class_q;
  logic [XLEN-1:0] int_q;
  logic [23:0]     mant_q;
  logic [5:0]      cnt_q;
  logic [XLEN:0]   mag_q;
  logic            inexact_q, ovf_q;

  logic signed [9:0] e_s;
  logic            is_nan, is_inf, is_special, early_ovf;
  logic            guard, sticky, round_up;

  assign e_s        = $signed({2'b00, exp_q}) - 10'sd127;
  assign is_nan     = class_q[8] | class_q[9];
  assign is_inf     = class_q[0] | class_q[7];
  // Anything that is not a (sub)normal number bypasses the shifter with a zero magnitude
  assign is_special = is_nan | is_inf | class_q[3] | class_q[4] |
                      ~(class_q[1] | class_q[2] | class_q[5] | class_q[6]);
  assign early_ovf  = w64_q ? (e_s >= 10'sd64) : (e_s >= 10'sd32);

`ifdef CELLRV32_F2I_BARREL_SHIFT_EN
  logic [XLEN+23:0] shifted;
  assign shifted = {int_q, mant_q} << cnt_q;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_i) state_d = S_PREPARE;
      S_PREPARE:  state_d = (is_special || early_ovf) ? S_FINALIZE : S_SHIFT;
`ifdef CELLRV32_F2I_BARREL_SHIFT_EN
      S_SHIFT:    state_d = S_ROUND;
`else
      S_SHIFT:    if (cnt_q == 6'd0) state_d = S_ROUND;
`endif
      S_ROUND:    state_d = S_FINALIZE;
      S_FINALIZE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (abort_i && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  always_comb begin
    guard  = mant_q[23];
    sticky = |mant_q[22:0];
    case (rmode_q)
      3'b000:  round_up = guard & (sticky | int_q[0]);
      3'b010:  round_up = sign_q & (guard | sticky);
      3'b011:  round_up = ~sign_q & (guard | sticky);
      3'b100:  round_up = guard;
      default: round_up = 1'b0;
    endcase
  end

  // Range check and result formatting on the rounded magnitude
  logic [XLEN:0]   lim_sp, lim_sn, lim_u;
  logic [XLEN-1:0] neg_x, sx, sat_p, sat_n, fin_res;
  logic            range_ovf, nv, pos;
  always_comb begin
    lim_sp    = w64_q ? {2'b00, {(XLEN-1){1'b1}}} : (XLEN+1)'(32'h7FFF_FFFF);
    lim_sn    = lim_sp + 1'b1;
    lim_u     = w64_q ? {1'b1, {XLEN{1'b0}}} : (XLEN+1)'(33'h1_0000_0000);
    if (uns_q) range_ovf = (mag_q >= lim_u) || (sign_q && (mag_q != '0));
    else       range_ovf = sign_q ? (mag_q > lim_sn) : (mag_q > lim_sp);
    nv        = is_nan | is_inf | ovf_q | range_ovf;
    pos       = is_nan | ~sign_q;
    neg_x     = sign_q ? (~mag_q[XLEN-1:0] + 1'b1) : mag_q[XLEN-1:0];
    sx        = XLEN'($signed(neg_x[31:0]));
    sat_p     = uns_q ? {XLEN{1'b1}} :
                (w64_q ? {1'b0, {(XLEN-1){1'b1}}} : XLEN'(32'h7FFF_FFFF));
    sat_n     = uns_q ? {XLEN{1'b0}} :
                (w64_q ? {1'b1, {(XLEN-1){1'b0}}} : XLEN'($signed(32'h8000_0000)));
    if (nv)         fin_res = pos ? sat_p : sat_n;
    else if (w64_q) fin_res = neg_x;
    else            fin_res = sx;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rmode_q   <= '0;
      uns_q     <= 1'b0;
      w64_q     <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      frac_q    <= '0;
      class_q   <= '0;
      int_q     <= '0;
      mant_q    <= '0;
      cnt_q     <= '0;
      mag_q     <= '0;
      inexact_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          rmode_q <= rmode_i;
          uns_q   <= funct_i[0];
          w64_q   <= (XLEN == 64) && funct_i[1];
          sign_q  <= sign_i;
          exp_q   <= exponent_i;
          frac_q  <= mantissa_i;
          class_q <= class_i;
          ovf_q   <= 1'b0;
        end
        S_PREPARE: begin
          cnt_q <= '0;
          if (is_special) begin
            mag_q     <= '0;
            inexact_q <= 1'b0;
          end else if (early_ovf) begin
            ovf_q <= 1'b1;
          end else if (e_s >= 10'sd0) begin
            int_q  <= XLEN'(1);
            mant_q <= {frac_q, 1'b0};
            cnt_q  <= e_s[5:0];
          end else if (e_s == -10'sd1) begin
            int_q  <= '0;
            mant_q <= {1'b1, frac_q};
          end else begin
            int_q  <= '0;
            mant_q <= 24'd1;
          end
        end
        S_SHIFT: begin
`ifdef CELLRV32_F2I_BARREL_SHIFT_EN
          {int_q, mant_q} <= shifted;
`else
          if (cnt_q != 6'd0) begin
            int_q  <= {int_q[XLEN-2:0], mant_q[23]};
            mant_q <= {mant_q[22:0], 1'b0};
            cnt_q  <= cnt_q - 6'd1;
          end
`endif
        end
        S_ROUND: begin
          mag_q     <= {1'b0, int_q} + (XLEN+1)'(round_up);
          inexact_q <= guard | sticky;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      result_o <= '0;
      flags_o  <= '0;
      done_o   <= 1'b0;
    end else if ((state_q == S_FINALIZE) && !abort_i) begin
      result_o <= fin_res;
      flags_o  <= {nv, 3'b000, ~nv & inexact_q};
      done_o   <= 1'b1;
    end else begin
      done_o   <= 1'b0;
    end
  end

endmodule

// File: doc/cellrv32_cpu_cp_fpu_f2i_gen.md
Name: cellrv32_cpu_cp_fpu_f2i_gen

Overview:
Parametrised successor to the single-precision float-to-int converter in the FPU co-processor. It converts a classified binary32 operand into a signed or unsigned integer of 32 bits, or of 64 bits when XLEN=64, using all five RISC-V rounding modes. Exception flags follow RISC-V semantics: out-of-range, NaN and infinity raise NV; inexact raises NX. The block is multi-cycle with start/abort/busy/done handshaking and sits beside the other FPU conversion units.

Parameters:
XLEN, 32, result width; legal values 32 or 64.

Ports:
clk_i  in  1  global clock, rising edge
rstn_i  in  1  global reset, async, active-low
start_i  in  1  start pulse; accepted only in S_IDLE
abort_i  in  1  cancel the running operation
rmode_i  in  3  rounding mode; sampled with start_i
funct_i  in  2  [0]=unsigned; [1]=64-bit target, legal only if XLEN=64, else treated as 0
sign_i  in  1  operand sign
exponent_i  in  8  biased exponent
mantissa_i  in  23  fraction
class_i  in  10  operand class, fp_class_*_c indexing
result_o  out  XLEN  integer result
flags_o  out  5  fp_exc_*_c indexing
busy_o  out  1  high from accept until done or abort
done_o  out  1  one-cycle completion pulse

Behaviour:
Interface:
- One clock, clk_i. Reset rstn_i is asynchronous and active-low.
- Reset values: result_o=0, flags_o=0, busy_o=0, done_o=0, FSM in S_IDLE.

Input capture and target width:
- On start in S_IDLE, all inputs including rmode_i are latched. Later input changes are ignored.
- start_i while busy is ignored.
- W = 64 if funct_i[1]=1 and XLEN=64, else W = 32.
- e = exponent - 127.

FSM:
- S_IDLE -> S_PREPARE.
- S_PREPARE:
  - NaN, inf or zero class -> S_FINALIZE.
  - e >= W -> overflow -> S_FINALIZE.
  - otherwise load int = hidden 1, mant = fraction -> S_SHIFT.
- S_SHIFT: shifts one bit per cycle for n = max(e,0) cycles, plus one exit cycle -> S_ROUND.
- S_ROUND -> S_FINALIZE -> S_IDLE. done_o pulses in the cycle after S_FINALIZE.

Latency (done_o high N cycles after the start cycle):
- N = 5+n on the normal path.
- N = 3 for special-class and early-overflow operands.

Fraction handling:
- e = -1: int = 0, guard = 1, sticky = |fraction.
- e < -1 or subnormal: int = 0, guard = 0, sticky = 1.
- Otherwise guard = first discarded bit and sticky = OR of the remaining discarded bits.

Rounding, applied to the magnitude:
- RNE: round up if guard and (sticky or LSB).
- RTZ: never round up.
- RDN: round up if negative and (guard or sticky).
- RUP: round up if positive and (guard or sticky).
- RMM: round up if guard.
- rmode 101/110/111 is treated as RTZ.
- The incrementer is W+1 bits wide; a carry out is an overflow.

Range check on the rounded magnitude M:
- Signed: positive M > 2^(W-1)-1 or negative M > 2^(W-1) -> overflow.
- Unsigned: M >= 2^W is overflow. Negative with M != 0 is also overflow.

Results:
- NaN or +inf or positive overflow: signed 2^(W-1)-1, unsigned all-ones.
- -inf or negative overflow: signed -2^(W-1), unsigned 0.
- Otherwise ±M, negated via two's complement.
- When XLEN=64 and W=32, the result is sign-extended from bit 31 to 64 bits for both signed and unsigned.

Flags:
- NV = NaN, inf or overflow.
- NX = rounded-in-range value inexact (guard or sticky), with NV=0.
- OF, UF and DZ are always 0.
- result_o and flags_o update together with done_o and hold until the next done_o.

Abort:
- abort_i in any busy state -> S_IDLE next cycle, busy_o=0, no done_o.
- result_o and flags_o are unchanged.
- abort_i has priority over a same-cycle FSM transition.
- abort_i in S_IDLE has no effect. A start_i in the same cycle as abort_i in S_IDLE is accepted.

Optional Feature:
CELLRV32_F2I_BARREL_SHIFT_EN
- Defined: S_SHIFT is replaced by a single-cycle barrel shift of {1,fraction} by e, producing int, guard and sticky in one cycle. Normal-path latency is fixed at N=5.
- Undefined: iterative shifter, N=5+n.
- Results and flags are identical in both builds.

Test Plan:
- 0x40200000 (+2.5), RNE, signed W=32 -> 0x00000002, NX=1, done at cycle 6 (barrel build: 5).
- 0xC0200000 (-2.5), RDN, signed -> 0xFFFFFFFD, NX=1; RMM -> 0xFFFFFFFD; RTZ -> 0xFFFFFFFE.
- 0x4F32D05E (3e9): signed -> 0x7FFFFFFF, NV=1; unsigned -> 0xB2D05E00, flags 0.
- 0x7FC00000 (qNaN), unsigned -> 0xFFFFFFFF, NV=1, done at cycle 3; 0xFF800000 (-inf), signed -> 0x80000000, NV=1; 0xBF800000 (-1.0), unsigned -> 0, NV=1.
- 0xBE99999A (-0.3): RDN signed -> 0xFFFFFFFF, NX=1; RTZ unsigned -> 0, NX=1, NV=0; abort_i in the 2nd S_SHIFT cycle of a start with 0x41200000 -> no done_o, busy_o=0 next cycle, prior result held.
- XLEN=64: 0xBF800000, funct=10 -> 0xFFFFFFFFFFFFFFFF; 0x4F800000, funct=01 -> 0xFFFFFFFFFFFFFFFF (sign-extended), NV=1.
